// File: rtl/tt_um_micro_reg_pkg.sv
// Shared types for the micro register responder: command encodings, FSM states, register-file geometry.
package tt_um_micro_reg_pkg;

   localparam int NUM_REGS = 4;
   localparam int ADDR_W   = 2;

   typedef enum logic [1:0] {
      CMD_SETADDR = 2'b00,
      CMD_WRLO    = 2'b01,
      CMD_WRHI    = 2'b10,
      CMD_READ    = 2'b11
   } cmd_t;

   typedef enum logic {
      IDLE    = 1'b0,
      LO_PEND = 1'b1
   } state_t;

endpackage

// File: rtl/micro_strobe_edge.sv
// Strobe edge detector: one fire pulse per rising strobe. strb_q resets high so a strobe
// already asserted when reset releases is not taken as a new command.
module micro_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic strb,
   output logic fire
);

   logic strb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) strb_q <= 1'b1;
      else        strb_q <= strb;
   end

   assign fire = strb & ~strb_q;

endmodule

// File: rtl/tt_um_micro_reg_responder.sv
// Strobed 4 x 8-bit register responder; bytes are written as low then high nibble, and reads are registered.
// Optional build macro MICRO_REG_CHECKSUM_EN adds an XOR-checksum read selected by arg[4].
//
// state   | meaning
// IDLE    | no low nibble held; WRHI here flags err
// LO_PEND | low nibble captured in lo_hold, waiting for WRHI
module tt_um_micro_reg_responder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out
);

   import tt_um_micro_reg_pkg::*;

   logic              fire;
   cmd_t              cmd;
   logic [4:0]        arg;
   state_t            state;
   state_t            state_nxt;
   logic [7:0]        regs [NUM_REGS];
   logic [ADDR_W-1:0] addr;
   logic [3:0]        lo_hold;
   logic              err;
   logic              do_setaddr;
   logic              do_wrlo;
   logic              do_write;
   logic              do_err;
   logic              do_read;
   logic [7:0]        rd_data;
   logic [7:0]        status;

   assign cmd = cmd_t'(ui_in[6:5]);
   assign arg = ui_in[4:0];

   micro_strobe_edge u_strobe (
      .clk   (clk),
      .rst_n (rst_n),
      .strb  (ui_in[7]),
      .fire  (fire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (fire) begin
         case (cmd)
            CMD_SETADDR: state_nxt = IDLE;
            CMD_WRLO:    state_nxt = LO_PEND;
            CMD_WRHI:    state_nxt = IDLE;
            default:     state_nxt = state;
         endcase
      end
   end

   always_comb begin
      do_setaddr = 1'b0;
      do_wrlo    = 1'b0;
      do_write   = 1'b0;
      do_err     = 1'b0;
      do_read    = 1'b0;
      if (fire) begin
         case (cmd)
            CMD_SETADDR: do_setaddr = 1'b1;
            CMD_WRLO:    do_wrlo    = 1'b1;
            CMD_WRHI: begin
               do_write = (state == LO_PEND);
               do_err   = (state == IDLE);
            end
            default:     do_read    = 1'b1;
         endcase
      end
   end

   assign status = {err, (state == LO_PEND), 4'b0000, addr};

`ifdef MICRO_REG_CHECKSUM_EN
   always_comb begin
      rd_data = arg[3] ? status : regs[addr];
      if (arg[4]) rd_data = regs[0] ^ regs[1] ^ regs[2] ^ regs[3];
   end
`else
   logic unused_arg;
   assign unused_arg = arg[4];
   assign rd_data    = arg[3] ? status : regs[addr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
         addr    <= '0;
         lo_hold <= 4'h0;
         err     <= 1'b0;
         uo_out  <= 8'h00;
      end else begin
         if (do_setaddr) begin
            addr    <= arg[ADDR_W-1:0];
            lo_hold <= 4'h0;
         end
         if (do_wrlo) lo_hold <= arg[3:0];
         if (do_write) begin
            regs[addr] <= {arg[3:0], lo_hold};
            addr       <= addr + 1'b1;
         end
         if (do_err)  err    <= 1'b1;
         if (do_read) uo_out <= rd_data;
      end
   end

endmodule

// File: tb/tb_tt_um_micro_reg_responder.sv
// Directed self-checking bench for tt_um_micro_reg_responder; expected values are hand-computed.
module tb_tt_um_micro_reg_responder;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   int         checks;
   int         failures;

   localparam logic [1:0] SETADDR = 2'b00;
   localparam logic [1:0] WRLO    = 2'b01;
   localparam logic [1:0] WRHI    = 2'b10;
   localparam logic [1:0] READ    = 2'b11;

   tt_um_micro_reg_responder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ui_in  (ui_in),
      .uo_out (uo_out)
   );

   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : 1'b0;

   task automatic send(input logic [1:0] c, input logic [4:0] a);
      @(negedge clk);
      ui_in = {1'b1, c, a};
      @(negedge clk);
      ui_in = 8'h00;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [4:0] a, output logic [7:0] v);
      send(READ, a);
      v = uo_out;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      apply_reset();
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_uo_out got=%h exp=%h", uo_out, 8'h00);
      end
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL reset_read_reg0 got=%h exp=%h", v, 8'h00);
      end
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL reset_status got=%h exp=%h", v, 8'h00);
      end
   endtask

   task automatic test_write_read();
      logic [7:0] v;
      send(SETADDR, 5'h02);
      send(WRLO, 5'h05);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h42) begin
         failures++;
         $display("FAIL pend_status got=%h exp=%h", v, 8'h42);
      end
      send(WRHI, 5'h0A);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h03) begin
         failures++;
         $display("FAIL post_write_status got=%h exp=%h", v, 8'h03);
      end
      send(SETADDR, 5'h02);
      do_read(5'h00, v);
      checks++;
      if (v !== 8'hA5) begin
         failures++;
         $display("FAIL read_reg2 got=%h exp=%h", v, 8'hA5);
      end
      send(SETADDR, 5'h00);
      send(WRLO, 5'h07);
      checks++;
      if (uo_out !== 8'hA5) begin
         failures++;
         $display("FAIL uo_out_hold got=%h exp=%h", uo_out, 8'hA5);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      send(SETADDR, 5'h03);
      for (int i = 0; i < 2; i++) begin
         send(WRLO, 5'h01);
         send(WRHI, 5'h02);
      end
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h01) begin
         failures++;
         $display("FAIL wrap_status got=%h exp=%h", v, 8'h01);
      end
      send(SETADDR, 5'h03);
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h21) begin
         failures++;
         $display("FAIL wrap_reg3 got=%h exp=%h", v, 8'h21);
      end
      send(SETADDR, 5'h00);
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h21) begin
         failures++;
         $display("FAIL wrap_reg0 got=%h exp=%h", v, 8'h21);
      end
   endtask

   task automatic test_err();
      logic [7:0] v;
      apply_reset();
      send(WRLO, 5'h03);
      send(SETADDR, 5'h00);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL setaddr_clears_pend got=%h exp=%h", v, 8'h00);
      end
      send(SETADDR, 5'h01);
      send(WRHI, 5'h07);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h81) begin
         failures++;
         $display("FAIL wrhi_idle_status got=%h exp=%h", v, 8'h81);
      end
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL wrhi_idle_reg1 got=%h exp=%h", v, 8'h00);
      end
      send(WRLO, 5'h02);
      send(WRHI, 5'h03);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h82) begin
         failures++;
         $display("FAIL err_sticky got=%h exp=%h", v, 8'h82);
      end
   endtask

   task automatic test_long_strobe();
      logic [7:0] v;
      apply_reset();
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         ui_in = {1'b1, (i % 2 == 1) ? WRHI : WRLO, 5'h03};
         @(negedge clk);
      end
      ui_in = 8'h00;
      @(negedge clk);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h40) begin
         failures++;
         $display("FAIL long_strobe_status got=%h exp=%h", v, 8'h40);
      end
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL long_strobe_reg0 got=%h exp=%h", v, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = {1'b1, WRHI, 5'h05};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      ui_in = 8'h00;
      @(negedge clk);
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL strobe_across_reset got=%h exp=%h", v, 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      apply_reset();
      send(WRLO, 5'h09);
      apply_reset();
      do_read(5'h08, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid_status got=%h exp=%h", v, 8'h00);
      end
      send(WRHI, 5'h04);
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid_reg0 got=%h exp=%h", v, 8'h00);
      end
   endtask

   task automatic test_deselect();
      logic [7:0] v;
      apply_reset();
      send(WRLO, 5'h0C);
      send(WRHI, 5'h03);
      @(negedge clk);
      clk_en = 1'b0;
      rst_n  = 1'b0;
      ui_in  = 8'h00;
      #100;
      rst_n  = 1'b1;
      #20;
      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("FAIL deselect_uo_out got=%h exp=%h", uo_out, 8'h00);
      end
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h00) begin
         failures++;
         $display("FAIL deselect_reg0 got=%h exp=%h", v, 8'h00);
      end
   endtask

   task automatic test_checksum();
      logic [7:0] v;
      logic [7:0] exp_sum;
      logic [7:0] exp_pri;
      apply_reset();
      send(WRLO, 5'h01); send(WRHI, 5'h00);
      send(WRLO, 5'h02); send(WRHI, 5'h00);
      send(WRLO, 5'h04); send(WRHI, 5'h00);
      send(WRLO, 5'h08); send(WRHI, 5'h00);
`ifdef MICRO_REG_CHECKSUM_EN
      exp_sum = 8'h0F;
      exp_pri = 8'h0F;
`else
      exp_sum = 8'h01;
      exp_pri = 8'h00;
`endif
      do_read(5'h10, v);
      checks++;
      if (v !== exp_sum) begin
         failures++;
         $display("FAIL checksum_read got=%h exp=%h", v, exp_sum);
      end
      do_read(5'h18, v);
      checks++;
      if (v !== exp_pri) begin
         failures++;
         $display("FAIL checksum_priority got=%h exp=%h", v, exp_pri);
      end
      send(SETADDR, 5'h03);
      do_read(5'h00, v);
      checks++;
      if (v !== 8'h08) begin
         failures++;
         $display("FAIL checksum_reg3 got=%h exp=%h", v, 8'h08);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clk_en   = 1'b1;
      rst_n    = 1'b0;
      ui_in    = 8'h00;
      test_reset();
      test_write_read();
      test_wrap();
      test_err();
      test_long_strobe();
      test_reset_mid();
      test_deselect();
      test_checksum();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
